// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the memory request arbiter: FSM state width and
// state encodings. Imported by mem_req_arbiter.
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Returns a one-hot vector selecting the
// first set request at or after index ptr+1, wrapping from NUM_REQ-1 to 0.
// Driving ptr with NUM_REQ-1 turns it into a fixed lowest-index-wins picker.
//
// Ports:
//   req   [NUM_REQ-1:0] request vector
//   ptr   [PTR_W-1:0]   index of the last granted requester
//   gnt   [NUM_REQ-1:0] one-hot pick (all zero when req is all zero)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic [NUM_REQ-1:0] above_ptr;
  logic [NUM_REQ-1:0] masked;

  function automatic logic [NUM_REQ-1:0] lowest_one(input logic [NUM_REQ-1:0] v);
    logic [NUM_REQ-1:0] r;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    above_ptr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      above_ptr[i] = (i > int'(ptr));
    end
    masked = req & above_ptr;
    // Requests above the pointer win; otherwise wrap around to the bottom.
    gnt = (|masked) ? lowest_one(masked) : lowest_one(req);
  end

endmodule : rr_pick

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
// Arbitrates NUM_REQ requesters onto one shared memory port. One owner at a
// time: IDLE picks an owner, REQ presents its payload until accepted,
// WAIT_RESP holds ownership until resp_done or a response timeout.
//
// Configuration macro: MEM_ARB_FIXED_PRIO_EN
//   undefined - round-robin, search starts after the last granted index
//   defined   - fixed priority, lowest index wins, no pointer register
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous active-high reset
//   req_valid    [NUM_REQ]              per-requester request valid
//   req_data     [NUM_REQ*DATA_WIDTH]   flattened payloads, requester i at slice i
//   req_ready    [NUM_REQ]              one-hot accept pulse to the owner
//   grant        [NUM_REQ]              one-hot current owner, zero when idle
//   out_valid                           request valid toward the shared port
//   out_ready                           shared port accepts the request
//   out_data     [DATA_WIDTH]           owner's payload (zero with no owner)
//   resp_done                           shared port completed the transaction
//   timeout_err                         one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module mem_req_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          resp_done,
  output logic                          timeout_err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   pick_ptr;
  logic               accept;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // A pointer pinned at the top index makes the picker start at index 0.
  assign pick_ptr = PTR_W'(NUM_REQ - 1);
`else
  logic [PTR_W-1:0] last_ptr;
  logic [PTR_W-1:0] grant_idx;

  assign pick_ptr = last_ptr;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req (req_valid),
    .ptr (pick_ptr),
    .gnt (pick)
  );

  // Handshake is combinational so req_ready pulses in the accepting cycle;
  // gated by reset so an abandoned transaction never reports acceptance.
  assign accept    = out_valid && out_ready && !reset;
  assign req_ready = grant & {NUM_REQ{accept}};

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      out_data = out_data | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_ptr    <= PTR_W'(NUM_REQ - 1);
`endif
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant     <= pick;
            out_valid <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            wait_cnt  <= '0;
            state     <= WAIT_RESP;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_ptr  <= grant_idx;
`endif
          end
        end
        WAIT_RESP: begin
          // resp_done is checked first so it wins over a same-cycle timeout.
          if (resp_done) begin
            grant <= '0;
            state <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            grant       <= '0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          grant     <= '0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule : mem_req_arbiter

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
// Directed self-checking bench for mem_req_arbiter (NUM_REQ=3, DATA_WIDTH=32,
// RESP_TIMEOUT=4). Inputs are driven and outputs sampled 1-2 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_mem_req_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DW      = 32;
  localparam int TMO     = 4;

  localparam logic [DW-1:0] P0 = 32'hA0A0_0000;
  localparam logic [DW-1:0] P1 = 32'hB1B1_1111;
  localparam logic [DW-1:0] P2 = 32'hC2C2_2222;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*DW-1:0]    req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       grant;
  logic                     out_valid;
  logic                     out_ready;
  logic [DW-1:0]            out_data;
  logic                     resp_done;
  logic                     timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_WIDTH   (DW),
    .RESP_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .grant       (grant),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .resp_done   (resp_done),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    resp_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 3'b111;
    out_ready = 1'b1;
    resp_done = 1'b0;
    tick();
    tick();
    #1;
    n_cmp++; if (grant !== 3'b000) begin n_err++; $display("FAIL reset_grant: got %b want %b", grant, 3'b000); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_req_ready: got %b want 000", req_ready); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    req_valid = '0;
    out_ready = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 3'b010;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_idle_valid: got %b want 0", out_valid); end
    tick();
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== P1) begin n_err++; $display("FAIL single_out_data: got %h want %h", out_data, P1); end
    n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL single_req_ready: got %b want 010", req_ready); end
    tick();
    req_valid = '0;
    resp_done = 1'b1;
    #1;
    n_cmp++; if (grant !== 3'b010) begin n_err++; $display("FAIL single_hold_grant: got %b want 010", grant); end
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL single_ready_pulse: got %b want 000", req_ready); end
    tick();
    resp_done = 1'b0;
    #1;
    n_cmp++; if (grant !== 3'b000) begin n_err++; $display("FAIL single_release: got %b want 000", grant); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL single_idle_data: got %h want 0", out_data); end
  endtask

  // Six back-to-back transactions with the given request pattern held.
  task automatic run_sequence(input string name, input logic [2:0] reqs,
                              input logic [2:0] e0, input logic [2:0] e1, input logic [2:0] e2,
                              input logic [2:0] e3, input logic [2:0] e4, input logic [2:0] e5);
    logic [2:0] exp_g [6];
    exp_g = '{e0, e1, e2, e3, e4, e5};
    do_reset();
    req_valid = reqs;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      n_cmp++; if (grant !== exp_g[k]) begin n_err++; $display("FAIL %s_grant[%0d]: got %b want %b", name, k, grant, exp_g[k]); end
      n_cmp++; if (req_ready !== exp_g[k]) begin n_err++; $display("FAIL %s_ready[%0d]: got %b want %b", name, k, req_ready, exp_g[k]); end
      tick();
      resp_done = 1'b1;
      tick();
      resp_done = 1'b0;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_fairness();
`ifdef MEM_ARB_FIXED_PRIO_EN
    run_sequence("fair", 3'b111, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001);
`else
    run_sequence("fair", 3'b111, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100);
`endif
  endtask

  task automatic test_priority();
`ifdef MEM_ARB_FIXED_PRIO_EN
    run_sequence("prio", 3'b101, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001);
`else
    run_sequence("prio", 3'b101, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100);
`endif
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 3'b100;
    out_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", k, out_valid); end
      n_cmp++; if (out_data !== P2) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", k, out_data, P2); end
      n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 000", k, req_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL bp_accept: got %b want 100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drop_valid: got %b want 0", out_valid); end
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
  endtask

  task automatic test_timeout();
    // No response: forced release after TMO WAIT_RESP cycles.
    do_reset();
    req_valid = 3'b001;
    out_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    for (int k = 0; k < TMO; k++) begin
      #1;
      n_cmp++; if (timeout_err !== 1'b0 || grant !== 3'b001) begin
        n_err++; $display("FAIL tmo_wait[%0d]: got te=%b grant=%b want te=0 grant=001", k, timeout_err, grant);
      end
      tick();
    end
    #1;
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_pulse: got %b want 1", timeout_err); end
    n_cmp++; if (grant !== 3'b000) begin n_err++; $display("FAIL tmo_release: got %b want 000", grant); end
    tick();
    #1;
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_single_pulse: got %b want 0", timeout_err); end

    // Response arriving on the last allowed cycle beats the timeout.
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    tick();
    for (int k = 0; k < TMO - 1; k++) tick();
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
    #1;
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_resp_wins: got %b want 0", timeout_err); end
    n_cmp++; if (grant !== 3'b000) begin n_err++; $display("FAIL tmo_resp_release: got %b want 000", grant); end
    tick();
    #1;
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_resp_late: got %b want 0", timeout_err); end
  endtask

  task automatic test_reset_mid();
    // Reset while waiting for a response.
    do_reset();
    req_valid = 3'b001;
    out_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    reset = 1'b1;
    tick();
    #1;
    n_cmp++; if (grant !== 3'b000) begin n_err++; $display("FAIL rst_wait_grant: got %b want 000", grant); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_wait_valid: got %b want 0", out_valid); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_wait_te: got %b want 0", timeout_err); end
    reset     = 1'b0;
    req_valid = 3'b110;
    out_ready = 1'b0;
    tick();
    #1;
    n_cmp++; if (grant !== 3'b010) begin n_err++; $display("FAIL rst_regrant: got %b want 010", grant); end

    // Reset while a request is presented and the port is ready.
    reset     = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL rst_req_ready: got %b want 000", req_ready); end
    tick();
    #1;
    n_cmp++; if (grant !== 3'b000) begin n_err++; $display("FAIL rst_req_grant: got %b want 000", grant); end
    reset     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    resp_done = 1'b0;
    req_data  = {P2, P1, P0};
    test_reset();
    test_single();
    test_fairness();
    test_priority();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1);
  end

endmodule : tb_mem_req_arbiter
